// File: rtl/bios_load_encoder.sv
// -----------------------------------------------------------------------------
// bios_load_encoder
//
// Host-side initiator for the BIOS serial command protocol. Converts a stream
// of (addr, data) words into BIOS command bytes on an AXI-stream style byte
// link. A load is bracketed by RST (on start) and BOOT (after the last word).
// Each word is sent as an optional ADR_UPPER, then ADR_LOWER and four
// WRITE_ONE..FOUR commands; ADR_UPPER is omitted when the upper address half
// matches the last one sent (UPPER_CACHE=1).
//
// Optional feature macro: BIOS_LOAD_VERIFY_EN
//   defined   - after each word, READ_ONE..FOUR are issued one at a time and
//               each readback byte is compared to the written byte; a
//               mismatch sets the sticky o_err (cleared by i_start).
//   undefined - no readback; o_rx_ready=0, o_err=0, i_rx_* ignored.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           one-cycle start pulse (honoured in IDLE/DONE only)
//   i_word_valid/o_word_ready, i_addr, i_data, i_last   word request
//   o_data/o_valid/i_ready                              command byte out
//   i_rx_data/i_rx_valid/o_rx_ready                     readback byte in
//   o_busy            not in IDLE/DONE
//   o_done            one-cycle pulse when BOOT is accepted
//   o_err             sticky verify mismatch
//   o_word_count      words fully sent, wraps at 16 bits
// -----------------------------------------------------------------------------
module bios_load_encoder #(
    parameter bit UPPER_CACHE  = 1'b1,
    parameter bit RST_ON_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_word_valid,
    output logic        o_word_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic        i_last,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_word_count
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SEND_RST, ST_WAIT_WORD, ST_SEND_WORD, ST_VERIFY, ST_SEND_BOOT, ST_DONE
    } state_e;

    localparam logic [7:0] OP_BOOT      = 8'h01;
    localparam logic [7:0] OP_RST       = 8'h02;
    localparam logic [7:0] OP_READ_ONE  = 8'h03;
    localparam logic [7:0] OP_ADR_LOWER = 8'h0B;
    localparam logic [7:0] OP_ADR_UPPER = 8'h0C;

    // Byte index within a word: 0..2 ADR_UPPER group, 3..5 ADR_LOWER group,
    // 6..13 WRITE_ONE..FOUR with their data bytes.
    localparam logic [3:0] IDX_UPPER_LAST = 4'd2;
    localparam logic [3:0] IDX_LOWER_OP   = 4'd3;
    localparam logic [3:0] IDX_LAST       = 4'd13;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        last_q;
    logic [3:0]  idx_q;
    logic [15:0] cache_q;
    logic        cache_vld_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        done_q;
    logic [15:0] count_q;
    logic        skip_upper;

    function automatic logic [7:0] word_byte(input logic [3:0]  idx,
                                             input logic [31:0] a,
                                             input logic [31:0] d);
        logic [7:0] b;
        case (idx)
            4'd0:    b = OP_ADR_UPPER;
            4'd1:    b = a[31:24];
            4'd2:    b = a[23:16];
            4'd3:    b = OP_ADR_LOWER;
            4'd4:    b = a[15:8];
            4'd5:    b = a[7:0];
            4'd6:    b = 8'h07;
            4'd7:    b = d[7:0];
            4'd8:    b = 8'h08;
            4'd9:    b = d[15:8];
            4'd10:   b = 8'h09;
            4'd11:   b = d[23:16];
            4'd12:   b = 8'h0A;
            default: b = d[31:24];
        endcase
        return b;
    endfunction

    // Compared against the incoming address so the first byte of the word can
    // be chosen in the acceptance cycle and presented on the very next clock.
    assign skip_upper = UPPER_CACHE && cache_vld_q && (cache_q == i_addr[31:16]);

`ifdef BIOS_LOAD_VERIFY_EN
    logic [1:0] rd_idx_q;
    logic       rd_wait_q;   // READ accepted, waiting for its readback byte
    logic       err_q;

    assign o_rx_ready = (state_q == ST_VERIFY) && rd_wait_q;
    assign o_err      = err_q;
`else
    logic unused_rx;

    assign unused_rx  = ^{i_rx_data, i_rx_valid};
    assign o_rx_ready = 1'b0;
    assign o_err      = 1'b0;
`endif

    // NOTE: the asynchronous reset clears tx_valid_q at once, so o_valid drops
    // mid-command without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            idx_q       <= '0;
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
`ifdef BIOS_LOAD_VERIFY_EN
            rd_idx_q    <= '0;
            rd_wait_q   <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking throughout; every branch reads pre-edge state.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        cache_vld_q <= 1'b0;
`ifdef BIOS_LOAD_VERIFY_EN
                        err_q       <= 1'b0;
`endif
                        if (RST_ON_START) begin
                            state_q    <= ST_SEND_RST;
                            tx_data_q  <= OP_RST;
                            tx_valid_q <= 1'b1;
                        end else begin
                            state_q    <= ST_WAIT_WORD;
                        end
                    end
                end
                ST_SEND_RST: begin
                    if (i_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= ST_WAIT_WORD;
                    end
                end
                ST_WAIT_WORD: begin
                    if (i_word_valid) begin
                        addr_q     <= i_addr;
                        data_q     <= i_data;
                        last_q     <= i_last;
                        idx_q      <= skip_upper ? IDX_LOWER_OP : 4'd0;
                        tx_data_q  <= skip_upper ? OP_ADR_LOWER : OP_ADR_UPPER;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_SEND_WORD;
                    end
                end
                ST_SEND_WORD: begin
                    if (i_ready) begin
                        if (idx_q == IDX_UPPER_LAST) begin
                            cache_q     <= addr_q[31:16];
                            cache_vld_q <= 1'b1;
                        end
                        if (idx_q == IDX_LAST) begin
                            count_q <= count_q + 16'd1;
`ifdef BIOS_LOAD_VERIFY_EN
                            state_q    <= ST_VERIFY;
                            tx_data_q  <= OP_READ_ONE;
                            rd_idx_q   <= '0;
                            rd_wait_q  <= 1'b0;
`else
                            if (last_q) begin
                                state_q   <= ST_SEND_BOOT;
                                tx_data_q <= OP_BOOT;
                            end else begin
                                state_q    <= ST_WAIT_WORD;
                                tx_valid_q <= 1'b0;
                            end
`endif
                        end else begin
                            idx_q     <= idx_q + 4'd1;
                            tx_data_q <= word_byte(idx_q + 4'd1, addr_q, data_q);
                        end
                    end
                end
`ifdef BIOS_LOAD_VERIFY_EN
                ST_VERIFY: begin
                    if (!rd_wait_q) begin
                        if (i_ready) begin
                            tx_valid_q <= 1'b0;
                            rd_wait_q  <= 1'b1;
                        end
                    end else if (i_rx_valid) begin
                        if (i_rx_data != data_q[{rd_idx_q, 3'b000} +: 8]) begin
                            err_q <= 1'b1;
                        end
                        if (rd_idx_q == 2'd3) begin
                            if (last_q) begin
                                state_q    <= ST_SEND_BOOT;
                                tx_data_q  <= OP_BOOT;
                                tx_valid_q <= 1'b1;
                            end else begin
                                state_q    <= ST_WAIT_WORD;
                            end
                        end else begin
                            rd_idx_q   <= rd_idx_q + 2'd1;
                            rd_wait_q  <= 1'b0;
                            tx_data_q  <= OP_READ_ONE + {6'd0, 2'(rd_idx_q + 2'd1)};
                            tx_valid_q <= 1'b1;
                        end
                    end
                end
`endif
                ST_SEND_BOOT: begin
                    if (i_ready) begin
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_data       = tx_data_q;
    assign o_valid      = tx_valid_q;
    assign o_word_ready = (state_q == ST_WAIT_WORD);
    assign o_busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_done       = done_q;
    assign o_word_count = count_q;

endmodule

// File: tb/tb_bios_load_encoder.sv
// -----------------------------------------------------------------------------
// tb_bios_load_encoder
//
// Self-checking bench for bios_load_encoder. A reference model builds the
// expected command-byte stream of a whole load from the protocol rules (RST,
// per-word address/write commands with an upper-address cache, optional
// readback commands, BOOT). Words, link back-pressure and readback timing are
// driven with $urandom; outputs are sampled on the falling clock edge.
// Honours BIOS_LOAD_VERIFY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_bios_load_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_word_valid = 1'b0;
    logic        o_word_ready;
    logic [31:0] i_addr = '0;
    logic [31:0] i_data = '0;
    logic        i_last = 1'b0;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [15:0] o_word_count;

    bios_load_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_word_valid (i_word_valid),
        .o_word_ready (o_word_ready),
        .i_addr       (i_addr),
        .i_data       (i_data),
        .i_last       (i_last),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_rx_ready   (o_rx_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_word_count (o_word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        last;
        logic        bad;    // readback of this word returns a wrong top byte
    } word_t;

    word_t      words[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] rx_q[$];

    // Reference model state
    logic [15:0] m_cache;
    logic        m_cache_vld;
    logic        m_err;
    logic [15:0] m_count = '0;

    // Driver / monitor state
    int         checks = 0;
    int         failures = 0;
    int         widx;
    int         done_cnt;
    logic       word_take;
    logic       rx_take;
    logic       stall_watch;
    logic [7:0] prev_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected link traffic of one word, straight from the command rules.
    task automatic model_word(input word_t w);
        logic [7:0] rb;
        if (!(m_cache_vld && m_cache == w.a[31:16])) begin
            exp_q.push_back(8'h0C);
            exp_q.push_back(w.a[31:24]);
            exp_q.push_back(w.a[23:16]);
            m_cache     = w.a[31:16];
            m_cache_vld = 1'b1;
        end
        exp_q.push_back(8'h0B);
        exp_q.push_back(w.a[15:8]);
        exp_q.push_back(w.a[7:0]);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'(8'h07 + k));
            exp_q.push_back(w.d[8*k +: 8]);
        end
        m_count = m_count + 16'd1;
`ifdef BIOS_LOAD_VERIFY_EN
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'(8'h03 + k));
            rb = w.d[8*k +: 8];
            if (w.bad && k == 3) rb = (rb == 8'h00) ? 8'hFF : 8'h00;
            rx_q.push_back(rb);
        end
        if (w.bad) m_err = 1'b1;
`else
        rb = 8'h00;
`endif
    endtask

    task automatic drive_word();
        if (widx < words.size()) begin
            i_word_valid = 1'b1;
            i_addr       = words[widx].a;
            i_data       = words[widx].d;
            i_last       = words[widx].last;
        end else begin
            i_word_valid = 1'b0;
        end
    endtask

    // One clock: outputs are stable at the falling edge; inputs set here are
    // sampled by the next rising edge, so handshakes are decided now.
    task automatic step(input int mode, input int cyc);
        @(negedge clk);
        if (stall_watch) begin
            check("stall_valid", 32'(o_valid), 32'd1);
            check("stall_data", 32'(o_data), 32'(prev_data));
        end
        if (word_take) begin
            word_take = 1'b0;
            widx++;
            drive_word();
        end
        if (rx_take) begin
            rx_take = 1'b0;
            void'(rx_q.pop_front());
        end
        i_start = 1'b0;
        case (mode)
            0:       i_ready = 1'b1;
            1:       i_ready = (cyc % 2 == 0);
            default: i_ready = ($urandom_range(0, 3) != 0);
        endcase
        i_rx_valid = (rx_q.size() > 0) && ($urandom_range(0, 2) != 0);
        i_rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        if (o_word_ready && i_word_valid) word_take = 1'b1;
        if (o_valid && i_ready) got_q.push_back(o_data);
        if (o_rx_ready && i_rx_valid) rx_take = 1'b1;
        if (o_done) done_cnt++;
        stall_watch = o_valid && !i_ready;
        prev_data   = o_data;
    endtask

    task automatic gen_words(input int n);
        logic [15:0] uppers[3];
        uppers[0] = 16'h0000;
        uppers[1] = 16'h0001;
        uppers[2] = 16'h8000;
        words.delete();
        for (int k = 0; k < n; k++) begin
            word_t w;
            w.a    = {uppers[$urandom_range(0, 2)], 16'($urandom)};
            w.d    = $urandom;
            w.last = (k == n - 1);
            w.bad  = ($urandom_range(0, 3) == 0);
            words.push_back(w);
        end
    endtask

    // Runs one full load of 'words'. With abort_at > 0 it returns as soon as
    // that many bytes have been handed over, leaving the DUT mid-command.
    task automatic run_load(input int mode, input int abort_at);
        logic finished;
        got_q.delete();
        exp_q.delete();
        rx_q.delete();
        done_cnt    = 0;
        widx        = 0;
        word_take   = 1'b0;
        rx_take     = 1'b0;
        stall_watch = 1'b0;
        m_cache_vld = 1'b0;
        m_err       = 1'b0;
        exp_q.push_back(8'h02);
        foreach (words[k]) model_word(words[k]);
        exp_q.push_back(8'h01);

        @(negedge clk);
        i_start = 1'b1;
        drive_word();
        finished = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step(mode, cyc);
            if (cyc == 0) check("busy_after_start", 32'(o_busy), 32'd1);
            if (mode == 2 && cyc == 20) i_start = 1'b1;  // must be ignored
            if (abort_at > 0 && got_q.size() == abort_at) return;
            if (done_cnt > 0) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) check("load_timeout", 32'd0, 32'd1);
        for (int cyc = 0; cyc < 4; cyc++) step(0, cyc);

        check("byte_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        check("done_pulses", done_cnt, 32'd1);
        check("word_count", 32'(o_word_count), 32'(m_count));
        check("err", 32'(o_err), 32'(m_err));
        check("busy_after_done", 32'(o_busy), 32'd0);
        check("word_ready_after_done", 32'(o_word_ready), 32'd0);
    endtask

    initial begin
        logic [7:0] spec_bytes[$];
        word_t w;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_word_ready", 32'(o_word_ready), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_rx_ready", 32'(o_rx_ready), 32'd0);
        check("rst_count", 32'(o_word_count), 32'd0);

        // Reference two-word load at full rate
        words.delete();
        w.a = 32'h0000_0010; w.d = 32'hDEADBEEF; w.last = 1'b0; w.bad = 1'b1;
        words.push_back(w);
        w.a = 32'h0000_0014; w.d = 32'h01020304; w.last = 1'b1; w.bad = 1'b0;
        words.push_back(w);
        run_load(0, 0);
`ifndef BIOS_LOAD_VERIFY_EN
        spec_bytes = '{8'h02,
                       8'h0C, 8'h00, 8'h00, 8'h0B, 8'h00, 8'h10, 8'h07, 8'hEF,
                       8'h08, 8'hBE, 8'h09, 8'hAD, 8'h0A, 8'hDE,
                       8'h0B, 8'h00, 8'h14, 8'h07, 8'h04, 8'h08, 8'h03,
                       8'h09, 8'h02, 8'h0A, 8'h01,
                       8'h01};
        check("ref_len", got_q.size(), spec_bytes.size());
        for (int i = 0; i < got_q.size() && i < spec_bytes.size(); i++)
            check($sformatf("ref_byte%0d", i), 32'(got_q[i]), 32'(spec_bytes[i]));
`endif

        // Single word with i_ready toggling every cycle
        words.delete();
        w.a = 32'h0000_0010; w.d = 32'hDEADBEEF; w.last = 1'b1; w.bad = 1'b0;
        words.push_back(w);
        run_load(1, 0);

        // Randomized loads with back-pressure and an ignored mid-load start
        for (int r = 0; r < 3; r++) begin
            gen_words(6 + r);
            run_load(2, 0);
        end

        // Reset in the middle of a word: after RST plus five word bytes
        words.delete();
        w.a = 32'h1234_5678; w.d = 32'hCAFEF00D; w.last = 1'b1; w.bad = 1'b0;
        words.push_back(w);
        run_load(0, 6);
        @(posedge clk);
        #1;
        check("valid_before_rst", 32'(o_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("valid_async_drop", 32'(o_valid), 32'd0);
        check("count_async_clear", 32'(o_word_count), 32'd0);
        i_word_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_count = '0;
        @(negedge clk);
        check("post_rst_busy", 32'(o_busy), 32'd0);
        check("post_rst_word_ready", 32'(o_word_ready), 32'd0);
        check("post_rst_count", 32'(o_word_count), 32'd0);

        // Resync load after the abort
        gen_words(4);
        run_load(2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
